mux_nx1_scan: RTL and testbench
===============================

// Module: mux_nx1_scan
// PURPOSE
//  Parametrised N-channel, WIDTH-bit registered multiplexer; next generation of the gate-level 4x1 mux.
//  Two modes: manual select, or auto-scan round-robin over all channels with a programmable dwell.
//  Output is a registered word with valid/ready handshake; feeds display/serialiser stages downstream.
// PARAMETERS
//  WIDTH  4   bits per channel
//  N      4   channel count, >=2, need not be a power of 2
//  SELW   2   select/pointer width, >= clog2(N)
//  DWELL  4   scan-mode cycles spent per channel before capture, >=1
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  in         in   N*WIDTH    flat bus; channel k = in[k*WIDTH +: WIDTH]
//  sel        in   SELW       manual channel select
//  mode       in   1          0 = manual, 1 = auto-scan
//  en         in   1          request capture (manual) / enable scanning (scan)
//  out        out  WIDTH      captured word
//  out_ch     out  SELW       channel index of out
//  out_valid  out  1          out/out_ch/sel_err valid
//  out_ready  in   1          downstream accepts when out_valid & out_ready
//  sel_err    out  1          captured with word: manual sel >= N
// BEHAVIOUR
//  - Reset (rst=1 at clk edge, any state, mid-scan included): out=0, out_ch=0, out_valid=0, sel_err=0,
//    scan ptr=0, dwell cnt=0, state IDLE. rst overrides all other inputs.
//  - FSM: IDLE, SCAN, VALID.
//    IDLE: en&!mode -> capture in[sel], go VALID. en&mode -> dwell cnt=0, go SCAN. else stay.
//    SCAN: en=0 -> IDLE; cnt cleared, ptr kept. mode=0 -> IDLE.
//      else cnt++; when cnt==DWELL-1: capture in[ptr], out_ch=ptr, ptr=(ptr==N-1)?0:ptr+1,
//      cnt=0, go VALID.
//    VALID: out_valid=1; out, out_ch, sel_err, ptr, cnt frozen while !out_ready.
//      On out_ready: if en&!mode capture in[sel] (stay VALID, back-to-back, no bubble);
//      elif en&mode go SCAN (cnt=0); else go IDLE.
//  - Capture latency: registered, 1 cycle from sampling edge to out visible.
//  - Manual throughput 1 word/cycle with out_ready held 1.
//  - Scan period DWELL+1 cycles per word with out_ready=1; order 0,1,..,N-1,0.
//  - sel >= N in manual: out=0, out_ch=sel, sel_err=1 for that word; normal capture clears sel_err.
//  - mode/sel sampled only at capture or state-exit decisions; changes mid-dwell do not move ptr.
//  - Inputs in[] are not held by the block; only the captured word is stable.
// CONFIGURATION
//  MUX_PARITY_EN defined: adds output out_par (1 bit) = ^out, registered with out, reset 0, frozen
//    with out under backpressure.
//  MUX_PARITY_EN undefined: out_par port absent; all other behaviour identical.
// TESTING
//  1 Manual: in={ch3=5,ch2=0,ch1=F,ch0=A}, sel=1, en 1 cycle -> next cycle out=F, out_ch=1, valid=1.
//  2 Backpressure: case 1 with out_ready=0 for 5 cycles, in changed to all 0 -> out holds F, valid=1;
//    ready=1, en=0 -> valid=0 next cycle.
//  3 Scan DWELL=4, mode=1, en=1, ready=1 -> out sequence A,F,0,5,A; out_ch 0,1,2,3,0; 5-cycle period.
//  4 N=3 scan -> out_ch wraps 2->0; manual sel=3 -> out=0, out_ch=3, sel_err=1; next sel=2 -> sel_err=0.
//  5 rst=1 for 2 cycles mid-dwell on ch2 -> all outputs 0, IDLE; next scan starts at ch0.
//  6 MUX_PARITY_EN: captures of B then 7 -> out_par 1 then 1; capture 3 -> 0. Build without macro
//    must compile and pass 1-5.

Source files
------------

// File: rtl/mux_nx1_scan_if.sv
// rtl/mux_nx1_scan_if.sv - channel/select/handshake bundle for mux_nx1_scan
//
// Purpose: groups the mux data inputs, select controls and the registered
// output handshake into one interface.
// Optional feature macro: MUX_PARITY_EN (adds out_par).
// Signals:
//   in        N*WIDTH  flat channel bus, channel k = in[k*WIDTH +: WIDTH]
//   sel       SELW     manual channel select
//   mode      1        0 = manual, 1 = auto-scan
//   en        1        capture request (manual) / scan enable (scan)
//   out       WIDTH    captured word
//   out_ch    SELW     channel index of out
//   out_valid 1        out/out_ch/sel_err valid
//   out_ready 1        downstream accept
//   sel_err   1        captured manual select was out of range
//   out_par   1        even parity of out (MUX_PARITY_EN only)
// Modports: slave = the mux, master = the stage driving it / consuming it.
interface mux_nx1_scan_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic [N*WIDTH-1:0] in;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic               en;
  logic [WIDTH-1:0]   out;
  logic [SELW-1:0]    out_ch;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;
`ifdef MUX_PARITY_EN
  logic               out_par;
`endif

  modport slave (
`ifdef MUX_PARITY_EN
    output out_par,
`endif
    input  in, sel, mode, en, out_ready,
    output out, out_ch, out_valid, sel_err
  );

  modport master (
`ifdef MUX_PARITY_EN
    input  out_par,
`endif
    output in, sel, mode, en, out_ready,
    input  out, out_ch, out_valid, sel_err
  );
endinterface

// File: rtl/mux_nx1_scan.sv
// rtl/mux_nx1_scan.sv - N-channel registered mux with manual select and round-robin auto-scan
//
// Purpose: captures one WIDTH-bit channel of a flat input bus into a
// registered output word with a valid/ready handshake. In manual mode the
// channel is picked by sel; in scan mode channels are visited 0..N-1 in
// turn, spending DWELL cycles on each before capturing it.
// Optional feature macro: MUX_PARITY_EN (registered out_par = ^out).
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  mux_nx1_scan_if.slave - in/sel/mode/en/out_ready in,
//        out/out_ch/out_valid/sel_err(/out_par) out
module mux_nx1_scan #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_nx1_scan_if.slave bus
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, VALID} state_t;

  state_t           state;
  logic [SELW-1:0]  ptr;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] out_q;
  logic [SELW-1:0]  out_ch_q;
  logic             valid_q;
  logic             err_q;
`ifdef MUX_PARITY_EN
  logic             par_q;
`endif

  // Explicit compare loop rather than a variable part-select so that
  // out-of-range indices (N not a power of two) select zero cleanly.
  function automatic logic [WIDTH-1:0] pick(input logic [N*WIDTH-1:0] bus_in,
                                            input logic [SELW-1:0]    idx);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SELW'(k)) w = bus_in[k*WIDTH +: WIDTH];
    end
    return w;
  endfunction

  logic [WIDTH-1:0] man_word;
  logic [WIDTH-1:0] scan_word;
  logic             sel_ok;
  logic [SELW-1:0]  ptr_next;
  logic             dwell_done;

  assign man_word   = pick(bus.in, bus.sel);
  assign scan_word  = pick(bus.in, ptr);
  assign sel_ok     = ({1'b0, bus.sel} < (SELW+1)'(N));
  assign ptr_next   = (ptr == SELW'(N-1)) ? '0 : ptr + 1'b1;
  assign dwell_done = (cnt == CNTW'(DWELL-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      out_q    <= '0;
      out_ch_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef MUX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && !bus.mode) begin
            out_q    <= man_word;
            out_ch_q <= bus.sel;
            err_q    <= !sel_ok;
`ifdef MUX_PARITY_EN
            par_q    <= ^man_word;
`endif
            valid_q  <= 1'b1;
            state    <= VALID;
          end else if (bus.en && bus.mode) begin
            cnt   <= '0;
            state <= SCAN;
          end
        end

        SCAN: begin
          // Leaving scan keeps ptr so the round-robin resumes where it stopped.
          if (!bus.en || !bus.mode) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (dwell_done) begin
            out_q    <= scan_word;
            out_ch_q <= ptr;
            err_q    <= 1'b0;
`ifdef MUX_PARITY_EN
            par_q    <= ^scan_word;
`endif
            ptr      <= ptr_next;
            cnt      <= '0;
            valid_q  <= 1'b1;
            state    <= VALID;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        VALID: begin
          // Everything holds until the downstream takes the word.
          if (bus.out_ready) begin
            if (bus.en && !bus.mode) begin
              out_q    <= man_word;
              out_ch_q <= bus.sel;
              err_q    <= !sel_ok;
`ifdef MUX_PARITY_EN
              par_q    <= ^man_word;
`endif
            end else if (bus.en && bus.mode) begin
              cnt     <= '0;
              valid_q <= 1'b0;
              state   <= SCAN;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_err   = err_q;
`ifdef MUX_PARITY_EN
  assign bus.out_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb/tb_mux_nx1_scan.sv - scoreboard testbench for mux_nx1_scan
module tb_mux_nx1_scan;
  localparam int WIDTH = 4;
  localparam int N     = 3;
  localparam int SELW  = 2;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_nx1_scan_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

  mux_nx1_scan #(.WIDTH(WIDTH), .N(N), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int data;
    int ch;
    int err;
  } word_t;

  word_t exp_q[$];
  word_t mon_w;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: a word is either being held for the consumer, a scan
  // dwell is in progress, or nothing is happening.
  bit    m_hold = 1'b0;
  bit    m_scan = 1'b0;
  int    m_cnt  = 0;
  int    m_ptr  = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int chan(input int k);
    return int'(bus.in >> (k * WIDTH)) & ((1 << WIDTH) - 1);
  endfunction

  function automatic word_t make_word(input int ch, input bit manual);
    word_t w;
    w.ch   = ch;
    w.err  = (manual && ch >= N) ? 1 : 0;
    w.data = (ch < N) ? chan(ch) : 0;
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_hold = 1'b0;
      m_scan = 1'b0;
      m_cnt  = 0;
      m_ptr  = 0;
    end else if (m_scan) begin
      if (!bus.en || !bus.mode) begin
        m_scan = 1'b0;
        m_cnt  = 0;
      end else if (m_cnt == DWELL - 1) begin
        exp_q.push_back(make_word(m_ptr, 1'b0));
        m_ptr  = (m_ptr + 1) % N;
        m_cnt  = 0;
        m_scan = 1'b0;
        m_hold = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (!m_hold || bus.out_ready) begin
      m_hold = 1'b0;
      if (bus.en && !bus.mode) begin
        exp_q.push_back(make_word(int'(bus.sel), 1'b1));
        m_hold = 1'b1;
      end else if (bus.en && bus.mode) begin
        m_scan = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // Monitor: every accepted word must match the oldest expected capture.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", int'(bus.out_valid), int'(m_hold));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got out=%0d ch=%0d expected none at %0t",
                   bus.out, bus.out_ch, $time);
        end else begin
          mon_w = exp_q.pop_front();
          check("out", int'(bus.out), mon_w.data);
          check("out_ch", int'(bus.out_ch), mon_w.ch);
          check("sel_err", int'(bus.sel_err), mon_w.err);
`ifdef MUX_PARITY_EN
          check("out_par", int'(bus.out_par), $countones(mon_w.data) % 2);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"}, int'(bus.out), 0);
    check({tag, "_out_ch"}, int'(bus.out_ch), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_sel_err"}, int'(bus.sel_err), 0);
`ifdef MUX_PARITY_EN
    check({tag, "_out_par"}, int'(bus.out_par), 0);
`endif
  endtask

  bit phase_mode;
  int guard;

  initial begin
    bus.in        = '0;
    bus.sel       = '0;
    bus.mode      = 1'b0;
    bus.en        = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Manual capture of ch1 held under backpressure while inputs change.
    bus.in  = {4'h0, 4'hF, 4'hA};
    bus.sel = 2'd1;
    bus.en  = 1'b1;
    step();
    bus.en = 1'b0;
    bus.in = '0;
    repeat (5) step();
    check("bp_hold_out", int'(bus.out), 15);
    check("bp_hold_ch", int'(bus.out_ch), 1);
    bus.out_ready = 1'b1;
    repeat (2) step();

    // Out-of-range select then a normal select.
    bus.in   = {4'h5, 4'h9, 4'h3};
    bus.mode = 1'b0;
    bus.en   = 1'b1;
    bus.sel  = 2'd3;
    step();
    bus.sel = 2'd2;
    step();
    bus.en = 1'b0;
    repeat (2) step();

    // Continuous scan with the consumer always ready.
    bus.in   = {4'h0, 4'hF, 4'hA};
    bus.mode = 1'b1;
    bus.en   = 1'b1;
    repeat (40) step();

    // Reset in the middle of the dwell on ch2; scan must restart at ch0.
    guard = 0;
    while (!(m_scan && m_ptr == 2 && m_cnt == 1) && guard < 100) begin
      step();
      guard++;
    end
    check("reach_ch2_dwell", int'(guard < 100), 1);
    rst = 1'b1;
    repeat (2) step();
    check_reset_outputs("midscan_rst");
    rst = 1'b0;
    repeat (20) step();

    // Randomized traffic with biased modes, backpressure and rare resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) phase_mode = $urandom_range(0, 1);
      bus.in        = ($urandom() & ((1 << (N * WIDTH)) - 1));
      bus.sel       = SELW'($urandom_range(0, 3));
      bus.mode      = ($urandom_range(0, 19) == 0) ? ~phase_mode : phase_mode;
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 299) == 0);
      step();
    end

    rst           = 1'b0;
    bus.en        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
